// File: rtl/fetch_queue.sv
// Instruction fetch front-end: owns the fetch PC, issues single outstanding
// word reads over req/ack, and queues returned instructions for decode.
module fetch_queue #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   start_i,
  output logic                   imem_req_o,
  output logic [31:0]            imem_addr_o,
  input  logic                   imem_ack_i,
  input  logic [31:0]            imem_data_i,
  input  logic                   redirect_i,
  input  logic [31:0]            redirect_pc_i,
  output logic                   inst_valid_o,
  input  logic                   inst_ready_i,
  output logic [31:0]            inst_o,
  output logic [31:0]            pc_o,
  output logic [31:0]            pc_plus4_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_REQ   = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t         r_state;
  state_t         w_state_nxt;

  logic [31:0]    r_pc;
  logic [31:0]    r_addr;
  logic [31:0]    r_inst [DEPTH];
  logic [31:0]    r_ipc  [DEPTH];
  logic [AW-1:0]  r_rd;
  logic [AW-1:0]  r_wr;
  logic [CW-1:0]  r_count;

  logic           w_pop;
  logic           w_push;
  logic [CW-1:0]  w_count_nxt;
  logic           w_room;
  logic [31:0]    w_redirect_pc;
  logic [31:0]    w_pc_nxt;
  logic           w_addr_load;

  // Handshake qualifiers shared by the FSM and the FIFO.
  assign w_pop         = (r_count != '0) && inst_ready_i;
  assign w_push        = (r_state == S_REQ) && imem_ack_i && !redirect_i;
  assign w_count_nxt   = redirect_i ? '0
                                    : r_count + CW'(w_push) - CW'(w_pop);
  assign w_room        = w_count_nxt < CW'(DEPTH);
  assign w_redirect_pc = redirect_pc_i & ~32'h0000_0003;

  // State register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic; a request can never be withdrawn once issued.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (start_i && !redirect_i && w_room) begin
          w_state_nxt = S_REQ;
        end
      end
      S_REQ: begin
        if (redirect_i) begin
          if (imem_ack_i) begin
            w_state_nxt = start_i ? S_REQ : S_IDLE;
          end else begin
            w_state_nxt = S_DRAIN;
          end
        end else if (imem_ack_i) begin
          w_state_nxt = (start_i && w_room) ? S_REQ : S_IDLE;
        end
      end
      S_DRAIN: begin
        if (imem_ack_i) begin
          w_state_nxt = start_i ? S_REQ : S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Output/datapath control: fetch PC update and new-request address load.
  always_comb begin
    w_pc_nxt    = r_pc;
    w_addr_load = 1'b0;
    if (redirect_i) begin
      w_pc_nxt = w_redirect_pc;
    end else if (w_push) begin
      w_pc_nxt = r_pc + 32'd4;
    end
    if ((w_state_nxt == S_REQ) && ((r_state == S_IDLE) || imem_ack_i)) begin
      w_addr_load = 1'b1;
    end
  end

  // Fetch PC and request address registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_pc   <= RESET_PC;
      r_addr <= RESET_PC;
    end else begin
      r_pc <= w_pc_nxt;
      if (w_addr_load) begin
        r_addr <= w_pc_nxt;
      end
    end
  end

  // Instruction FIFO; storage is cleared on reset so the head reads as zero.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_rd    <= '0;
      r_wr    <= '0;
      r_count <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        r_inst[i] <= '0;
        r_ipc[i]  <= '0;
      end
    end else begin
      r_count <= w_count_nxt;
      if (redirect_i) begin
        r_rd <= '0;
        r_wr <= '0;
      end else begin
        if (w_push) begin
          r_inst[r_wr] <= imem_data_i;
          r_ipc[r_wr]  <= r_addr;
          r_wr         <= r_wr + AW'(1);
        end
        if (w_pop) begin
          r_rd <= r_rd + AW'(1);
        end
      end
    end
  end

  assign imem_req_o   = (r_state != S_IDLE);
  assign imem_addr_o  = r_addr;
  assign inst_valid_o = (r_count != '0);
  assign inst_o       = r_inst[r_rd];
  assign pc_o         = r_ipc[r_rd];
  assign pc_plus4_o   = r_ipc[r_rd] + 32'd4;
  assign count_o      = r_count;

endmodule
